// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared UART definitions: receiver state encodings and the bit-period helper.
// TX uses the same helper so that both ends of the link agree on the bit period.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
    return (freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
`timescale 1ns/1ps
// Two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so the line reads idle during and just after reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_v1.sv
`timescale 1ns/1ps
// UART receiver, 8N1 LSB first, mid-bit sampling, valid/ready output hold register.
// Define UART_RX_PARITY_EN to receive 8E1/8O1 frames (PARITY_ODD selects the sense).
module uart_rx_v1
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 1_840_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter bit          PARITY_ODD  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_s;
  logic                 par_ok;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign par_ok = ~par_bad;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign par_ok            = 1'b1;
  assign parity_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
      par_bad     <= 1'b0;
`endif
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      // Consumer handshake; a delivery below on the same edge overrides this clear.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        ST_START: begin
          if (cnt == CNT_MID) begin
            cnt     <= '0;
            bit_cnt <= '0;
            if (!rx_s) begin
              state <= ST_DATA;
`ifdef UART_RX_PARITY_EN
              par_bad <= 1'b0;
`endif
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bad <= rx_s ^ (^shift) ^ PARITY_ODD;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif

        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
`ifdef UART_RX_PARITY_EN
            parity_err <= par_bad;
`endif
            if (!rx_s) begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              if (par_ok) begin
                if (!rx_valid || rx_ready) begin
                  rx_data  <= shift;
                  rx_valid <= 1'b1;
                end else begin
                  overrun_err <= 1'b1;
                end
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Line held low after a bad stop bit: wait for idle before re-arming.
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_v1.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_rx_v1: the driver pushes expected bytes, a negedge monitor
// pops and compares on every rx_valid&rx_ready transfer and tallies error pulses.
module tb_uart_rx_v1;
  import uart_pkg::*;

  localparam int unsigned CLK_FREQ_HZ = 1_840_000;
  localparam int unsigned BAUD_RATE   = 115_200;
  localparam int unsigned CPB         = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned HALF        = CPB / 2;
  localparam int          CLK_NS      = 20;
  localparam int          BIT_NS      = int'(CPB) * CLK_NS;
`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  int         rx_cnt = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         pe_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_v1 #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD_RATE   (BAUD_RATE),
    .PARITY_ODD  (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  always #(CLK_NS / 2) clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard compare on each accepted byte, pulse tallies.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err)   fe_cnt++;
      if (overrun_err) ov_cnt++;
      if (parity_err)  pe_cnt++;
      if (rx_valid && rx_ready) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got byte 0x%02h, expected none", rx_data);
        end else begin
          chk("sb_byte", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(BIT_NS);
    end
    if (HAS_PAR) begin
      rx = par_bit;
      #(BIT_NS);
    end
    rx = stop_bit;
    #(BIT_NS);
  endtask

  task automatic send(input logic [7:0] d);
    drive_frame(d, 1'b1, ^d);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    #(n * BIT_NS);
  endtask

  initial begin
    logic [7:0] b5a;
    b5a = 8'h5A;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun_err", 32'(overrun_err), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    rst_n = 1'b1;
    rx_ready = 1'b1;
    idle_bits(2);

    // Single byte
    align();
    exp_q.push_back(8'hA5);
    send(8'hA5);
    idle_bits(2);
    chk("a5_count", 32'(rx_cnt), 32'd1);
    chk("a5_no_frame_err", 32'(fe_cnt), 32'd0);
    chk("a5_busy_idle", 32'(busy), 32'd0);

    // Back-to-back extremes
    align();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send(8'h00);
    send(8'hFF);
    idle_bits(2);
    chk("b2b_count", 32'(rx_cnt), 32'd3);
    chk("b2b_no_frame_err", 32'(fe_cnt), 32'd0);

    // Start-bit glitch of 100 ns
    align();
    rx = 1'b0;
    #100;
    chk("glitch_busy_high", 32'(busy), 32'd1);
    rx = 1'b1;
    #((int'(HALF) + 3) * CLK_NS - 100 + 10);
    chk("glitch_busy_low", 32'(busy), 32'd0);
    idle_bits(1);
    chk("glitch_no_byte", 32'(rx_cnt), 32'd3);

    // Bad stop bit, line held low afterwards
    align();
    drive_frame(8'h3C, 1'b0, ^8'h3C);
    #(3 * BIT_NS);
    chk("fe_pulse_once", 32'(fe_cnt), 32'd1);
    chk("fe_busy_break", 32'(busy), 32'd1);
    chk("fe_no_valid", 32'(rx_valid), 32'd0);
    idle_bits(1);
    chk("fe_busy_released", 32'(busy), 32'd0);
    chk("fe_no_byte", 32'(rx_cnt), 32'd3);

    // Overrun while consumer stalled
    align();
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send(8'h11);
    send(8'h22);
    idle_bits(2);
    chk("ovr_valid_held", 32'(rx_valid), 32'd1);
    chk("ovr_data_held", 32'(rx_data), 32'h11);
    chk("ovr_pulse_once", 32'(ov_cnt), 32'd1);
    align();
    rx_ready = 1'b1;
    align();
    align();
    chk("ovr_valid_dropped", 32'(rx_valid), 32'd0);
    chk("ovr_count", 32'(rx_cnt), 32'd4);

    // Reset pulse during data bit 4
    align();
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = b5a[i];
      #(BIT_NS);
    end
    rx = b5a[4];
    #(BIT_NS / 2);
    chk("mid_busy_before", 32'(busy), 32'd1);
    align();
    rst_n = 1'b0;
    align();
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_data", 32'(rx_data), 32'h00);
    idle_bits(12);
    align();
    exp_q.push_back(8'h5A);
    send(8'h5A);
    idle_bits(2);
    chk("post_rst_count", 32'(rx_cnt), 32'd5);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1
    align();
    drive_frame(8'h07, 1'b1, 1'b0);
    idle_bits(2);
    chk("par_err_pulse", 32'(pe_cnt), 32'd1);
    chk("par_err_dropped", 32'(rx_cnt), 32'd5);
    align();
    exp_q.push_back(8'h07);
    drive_frame(8'h07, 1'b1, 1'b1);
    idle_bits(2);
    chk("par_ok_count", 32'(rx_cnt), 32'd6);
    chk("par_ok_no_err", 32'(pe_cnt), 32'd1);
`else
    chk("no_parity_pulses", 32'(pe_cnt), 32'd0);
`endif

    // Final tallies
    chk("final_frame_errs", 32'(fe_cnt), 32'd1);
    chk("final_overruns", 32'(ov_cnt), 32'd1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
